uart_fifo_tx_sequencer: RTL and testbench
=========================================

Name: uart_fifo_tx_sequencer

Overview:
Controller between the host write path, the 128x8 UART FIFO (fifo_ctrl_128 style: active-low strobes, registered output) and the UART transmitter.
- Gates host writes against FIFO full and flags overflow.
- Issues single-cycle FIFO read strobes.
- Accounts for the FIFO's two-cycle read latency.
- Presents each byte to the transmitter with a valid/ready handshake, one byte in flight at a time.

Parameters:
RD_LATENCY, 2, clock edges from the edge that samples fifo_read_n low to the edge after which fifo_data_out holds the popped byte (legal 1..7)
CNT_WIDTH, 16, width of the transmitted-byte counter

Ports:
clock  input  1  system clock; also clocks the FIFO
reset_n  input  1  asynchronous, active-low reset
enable  input  1  1 = drain FIFO to transmitter
wr_en  input  1  host write request, one byte per cycle high
wr_data  input  8  host write byte
fifo_write_n  output  1  FIFO write strobe, active low
fifo_data_in  output  8  FIFO write data
fifo_read_n  output  1  FIFO read strobe, active low
fifo_data_out  input  8  FIFO read data
fifo_full  input  1  FIFO full (127 entries)
fifo_empty  input  1  FIFO empty
tx_data  output  8  byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte when high with tx_valid
overflow  output  1  sticky: a host write was dropped
clr_overflow  input  1  synchronous clear of overflow
busy  output  1  state != IDLE
tx_count  output  CNT_WIDTH  bytes accepted by transmitter, wraps

Behaviour:
- Reset values: fifo_write_n=1, fifo_read_n=1, fifo_data_in=0, tx_data=0, tx_valid=0, overflow=0, busy=0, tx_count=0, state=IDLE, latency counter=0.
- Write path (registered, 1-cycle latency):
  - wr_en=1 and fifo_full=0: next cycle fifo_write_n=0 for exactly one cycle, fifo_data_in=wr_data.
  - wr_en=1 and fifo_full=1: write dropped, fifo_write_n stays 1, overflow set next cycle.
  - Back-to-back wr_en produces back-to-back write strobes.
  - A write issued in the cycle full rises (registered write already in flight) is not the block's responsibility; the host must respect the 1-cycle lag.
- overflow: set has priority over clr_overflow in the same cycle.
- FSM states: IDLE, READ, WAIT, PRESENT.
  - IDLE: if enable=1 and fifo_empty=0, go to READ. Otherwise stay.
  - READ: fifo_read_n=0 for exactly this one cycle. Load latency counter with RD_LATENCY-1. Go to WAIT.
  - WAIT: decrement the counter each cycle. At 0, capture fifo_data_out into tx_data, set tx_valid=1, go to PRESENT.
  - PRESENT: hold tx_valid and tx_data stable until tx_ready=1. On the handshake edge: tx_valid=0, tx_count+=1 (mod 2^CNT_WIDTH), go to IDLE.
- Minimum spacing: one byte per RD_LATENCY+3 cycles with tx_ready tied high.
- fifo_read_n is never low while fifo_empty=1 was sampled in the preceding IDLE cycle. No speculative reads.
- enable deassert mid-byte: the current byte completes through PRESENT. The FSM then stays in IDLE. No partial bytes are discarded.
- Simultaneous host write and FSM read in the same cycle is legal. The FIFO nets the count; the block adds no interlock.
- Reset mid-operation clears all state immediately. An in-flight byte is lost (the FIFO is reset on the same reset_n).
- tx_valid never drops without a handshake (verification assertion).

Test Plan:
1. Reset then write 0xA5, 0x3C with enable=1, tx_ready=1 -> fifo_write_n low two consecutive cycles; tx_data=0xA5 then 0x3C, each with tx_valid for one cycle; tx_count=2; busy=0 afterwards.
2. tx_ready held 0 for 20 cycles after tx_valid rises on 0x11 -> tx_valid=1 and tx_data=0x11 stable all 20 cycles; tx_count increments only on the cycle tx_ready=1.
3. Fill FIFO to full (127 writes, enable=0), then one more write 0xFF -> fifo_write_n stays 1 for it; overflow=1. Assert clr_overflow -> overflow=0. Assert clr_overflow together with a dropped write -> overflow stays 1.
4. enable=1 with FIFO empty for 50 cycles -> fifo_read_n never 0, busy=0. Write one byte -> exactly one read strobe; latency from fifo_read_n low to tx_valid is RD_LATENCY+1 cycles (3 at default).
5. Drop enable during WAIT of byte 0x42 -> 0x42 is still delivered; no further reads while enable=0; re-enable resumes with the next FIFO byte in order.
6. Assert reset_n=0 during PRESENT -> tx_valid=0 and tx_count=0 asynchronously; after release the FSM is in IDLE and the FIFO is empty.

Source files
------------

// File: rtl/uart_fifo_tx_sequencer.sv
// Sits between the host write path, the 128x8 UART FIFO and the UART transmitter:
// gates host writes against full, pops one byte at a time and hands it over valid/ready.
module uart_fifo_tx_sequencer #(
    parameter int RD_LATENCY = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    output logic                 fifo_write_n,
    output logic [7:0]           fifo_data_in,
    output logic                 fifo_read_n,
    input  logic [7:0]           fifo_data_out,
    input  logic                 fifo_full,
    input  logic                 fifo_empty,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 overflow,
    input  logic                 clr_overflow,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] tx_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LATENCY - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_lat_cnt;
    logic [2:0]           w_lat_cnt_next;
    logic                 w_capture;
    logic                 w_handshake;
    logic                 w_wr_accept;
    logic                 w_wr_drop;

    logic                 r_fifo_write_n;
    logic [7:0]           r_fifo_data_in;
    logic                 r_overflow;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic [CNT_WIDTH-1:0] r_tx_count;

    assign w_wr_accept = wr_en & ~fifo_full;
    assign w_wr_drop   = wr_en & fifo_full;

    // Write strobe is registered so the FIFO sees a clean one-cycle low pulse per accepted byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo_write_n <= 1'b1;
            r_fifo_data_in <= 8'h00;
            r_overflow     <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            r_fifo_write_n <= ~w_wr_accept;
            if (w_wr_accept)
                r_fifo_data_in <= wr_data;
            if (w_wr_drop)
                r_overflow <= 1'b1;
            else if (clr_overflow)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_lat_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_next;
            r_lat_cnt <= w_lat_cnt_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        w_state_next   = r_state;
        w_lat_cnt_next = r_lat_cnt;
        w_capture      = 1'b0;
        w_handshake    = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && !fifo_empty)
                    w_state_next = READ;
            end
            READ: begin
                w_lat_cnt_next = LAT_LOAD;
                w_state_next   = WAIT;
            end
            WAIT: begin
                if (r_lat_cnt == 3'd0) begin
                    w_capture    = 1'b1;
                    w_state_next = PRESENT;
                end else begin
                    w_lat_cnt_next = r_lat_cnt - 3'd1;
                end
            end
            PRESENT: begin
                if (tx_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // tx_data is only loaded on capture, so it stays stable for the whole PRESENT stall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_count <= '0;
        end else begin
            if (w_capture) begin
                r_tx_data  <= fifo_data_out;
                r_tx_valid <= 1'b1;
            end else if (w_handshake) begin
                r_tx_valid <= 1'b0;
                r_tx_count <= r_tx_count + CNT_WIDTH'(1);
            end
        end
    end

    assign fifo_write_n = r_fifo_write_n;
    assign fifo_data_in = r_fifo_data_in;
    assign fifo_read_n  = (r_state != READ);
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign overflow     = r_overflow;
    assign busy         = (r_state != IDLE);
    assign tx_count     = r_tx_count;

endmodule

// File: tb/tb_uart_fifo_tx_sequencer.sv
// Directed bench for uart_fifo_tx_sequencer with a behavioural 128x8 FIFO
// (127-entry full, active-low strobes, two-cycle registered read path).
module tb_uart_fifo_tx_sequencer;

    localparam int RD_LATENCY = 2;
    localparam int CNT_WIDTH  = 16;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 wr_en = 1'b0;
    logic [7:0]           wr_data = 8'h00;
    logic                 fifo_write_n;
    logic [7:0]           fifo_data_in;
    logic                 fifo_read_n;
    logic [7:0]           fifo_data_out;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready = 1'b0;
    logic                 overflow;
    logic                 clr_overflow = 1'b0;
    logic                 busy;
    logic [CNT_WIDTH-1:0] tx_count;

    int checks = 0;
    int errors = 0;

    uart_fifo_tx_sequencer #(
        .RD_LATENCY(RD_LATENCY),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_write_n (fifo_write_n),
        .fifo_data_in (fifo_data_in),
        .fifo_read_n  (fifo_read_n),
        .fifo_data_out(fifo_data_out),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .busy         (busy),
        .tx_count     (tx_count)
    );

    always #5 clock = ~clock;

    // Behavioural FIFO: pop on the edge sampling read low, data valid after the next edge.
    logic [7:0] mem [128];
    logic [6:0] wp, rp;
    logic [7:0] fcount;
    logic [7:0] s1;
    logic       s1v;
    logic       m_wr, m_rd;

    assign fifo_full  = (fcount >= 8'd127);
    assign fifo_empty = (fcount == 8'd0);
    assign m_wr = !fifo_write_n && !fifo_full;
    assign m_rd = !fifo_read_n && !fifo_empty;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp <= '0; rp <= '0; fcount <= '0;
            s1 <= '0; s1v <= 1'b0; fifo_data_out <= '0;
        end else begin
            if (m_wr) begin
                mem[wp] <= fifo_data_in;
                wp <= wp + 7'd1;
            end
            if (m_rd) begin
                s1 <= mem[rp];
                rp <= rp + 7'd1;
            end
            s1v <= m_rd;
            if (s1v)
                fifo_data_out <= s1;
            fcount <= fcount + 8'(m_wr) - 8'(m_rd);
        end
    end

    // Transaction monitor: accepted bytes, read strobes and handshake-rule violations.
    logic [7:0] accepted [$];
    int   reads = 0;
    int   empty_reads = 0;
    int   valid_cycles = 0;
    int   hold_viol = 0;
    logic prev_valid, prev_ready;
    logic [7:0] prev_data;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_data  <= 8'h00;
        end else begin
            if (!fifo_read_n) reads <= reads + 1;
            if (!fifo_read_n && fifo_empty) empty_reads <= empty_reads + 1;
            if (tx_valid && tx_ready) accepted.push_back(tx_data);
            if (tx_valid) valid_cycles <= valid_cycles + 1;
            if (prev_valid && !prev_ready && (!tx_valid || tx_data != prev_data))
                hold_viol <= hold_viol + 1;
            prev_valid <= tx_valid;
            prev_ready <= tx_ready;
            prev_data  <= tx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid_timeout"}, 32'(n < 100), 32'd1);
    endtask

    task automatic wait_read(input string tag);
        int n = 0;
        while (fifo_read_n && n < 100) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_read_timeout"}, 32'(n < 100), 32'd1);
    endtask

    int base, rbase, vbase, bad, stable, bsy, lat;

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        check("rst_write_n", fifo_write_n, 1);
        check("rst_read_n", fifo_read_n, 1);
        check("rst_data_in", fifo_data_in, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_count", tx_count, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1: two back-to-back writes drained with tx_ready high
        enable = 1'b1; tx_ready = 1'b1;
        base = accepted.size(); vbase = valid_cycles;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge clock);
        check("t1_strobe0", fifo_write_n, 0);
        check("t1_data0", fifo_data_in, 8'hA5);
        wr_data = 8'h3C;
        @(negedge clock);
        check("t1_strobe1", fifo_write_n, 0);
        check("t1_data1", fifo_data_in, 8'h3C);
        wr_en = 1'b0;
        @(negedge clock);
        check("t1_strobe_end", fifo_write_n, 1);
        repeat (20) @(negedge clock);
        check("t1_nbytes", accepted.size() - base, 2);
        if (accepted.size() >= base + 2) begin
            check("t1_byte0", accepted[base], 8'hA5);
            check("t1_byte1", accepted[base+1], 8'h3C);
        end
        check("t1_valid_cycles", valid_cycles - vbase, 2);
        check("t1_count", tx_count, 2);
        check("t1_busy", busy, 0);

        // 2: 20-cycle stall in PRESENT
        tx_ready = 1'b0;
        base = accepted.size();
        write_byte(8'h11);
        wait_valid("t2");
        stable = 0;
        repeat (20) begin
            if (tx_valid && tx_data == 8'h11) stable++;
            @(negedge clock);
        end
        check("t2_stable", stable, 20);
        check("t2_count_held", tx_count, 2);
        tx_ready = 1'b1;
        @(negedge clock);
        check("t2_valid_drop", tx_valid, 0);
        check("t2_count", tx_count, 3);
        check("t2_nbytes", accepted.size() - base, 1);

        // 3: fill to full, overflow set/clear priority, then drain in order
        enable = 1'b0;
        for (int i = 0; i < 127; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge clock);
        end
        wr_en = 1'b0;
        repeat (3) @(negedge clock);
        check("t3_no_overflow_yet", overflow, 0);
        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clock);
        wr_en = 1'b0;
        check("t3_drop_strobe", fifo_write_n, 1);
        check("t3_overflow_set", overflow, 1);
        clr_overflow = 1'b1;
        @(negedge clock);
        clr_overflow = 1'b0;
        check("t3_overflow_clr", overflow, 0);
        wr_en = 1'b1; clr_overflow = 1'b1;
        @(negedge clock);
        wr_en = 1'b0; clr_overflow = 1'b0;
        check("t3_set_beats_clr", overflow, 1);
        check("t3_drop_strobe2", fifo_write_n, 1);
        base = accepted.size();
        enable = 1'b1;
        repeat (127 * (RD_LATENCY + 3) + 20) @(negedge clock);
        check("t3_nbytes", accepted.size() - base, 127);
        bad = 0;
        for (int i = 0; i < 127; i++)
            if (base + i >= accepted.size() || accepted[base+i] != 8'(i)) bad++;
        check("t3_order_errors", bad, 0);
        check("t3_count", tx_count, 130);
        check("t3_busy", busy, 0);
        clr_overflow = 1'b1;
        @(negedge clock);
        clr_overflow = 1'b0;

        // 4: empty FIFO never read, then read-to-valid latency
        rbase = reads; bsy = 0;
        repeat (50) begin
            if (busy) bsy++;
            @(negedge clock);
        end
        check("t4_no_reads", reads - rbase, 0);
        check("t4_never_busy", bsy, 0);
        base = accepted.size();
        write_byte(8'h5A);
        wait_read("t4");
        lat = 0;
        while (!tx_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("t4_latency", lat, RD_LATENCY + 1);
        check("t4_data", tx_data, 8'h5A);
        repeat (10) @(negedge clock);
        check("t4_one_read", reads - rbase, 1);
        check("t4_nbytes", accepted.size() - base, 1);

        // 5: drop enable during WAIT of 0x42
        base = accepted.size(); rbase = reads;
        write_byte(8'h42);
        write_byte(8'h43);
        write_byte(8'h44);
        wait_read("t5");
        @(negedge clock);
        check("t5_in_wait", busy, 1);
        enable = 1'b0;
        repeat (30) @(negedge clock);
        check("t5_nbytes_paused", accepted.size() - base, 1);
        if (accepted.size() > base)
            check("t5_byte42", accepted[base], 8'h42);
        check("t5_reads_paused", reads - rbase, 1);
        check("t5_busy_paused", busy, 0);
        enable = 1'b1;
        repeat (30) @(negedge clock);
        check("t5_nbytes", accepted.size() - base, 3);
        if (accepted.size() >= base + 3) begin
            check("t5_byte43", accepted[base+1], 8'h43);
            check("t5_byte44", accepted[base+2], 8'h44);
        end
        check("t5_reads", reads - rbase, 3);

        // 6: asynchronous reset during PRESENT
        tx_ready = 1'b0;
        write_byte(8'h77);
        write_byte(8'h78);
        wait_valid("t6");
        @(negedge clock);
        check("t6_present", tx_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_valid", tx_valid, 0);
        check("t6_async_count", tx_count, 0);
        check("t6_async_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        rbase = reads;
        repeat (10) @(negedge clock);
        check("t6_idle", busy, 0);
        check("t6_fifo_empty", fifo_empty, 1);
        check("t6_no_reads", reads - rbase, 0);

        check("hold_violations", hold_viol, 0);
        check("empty_reads", empty_reads, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
